// File: rtl/spi_pkg.sv
// Shared SPI responder definitions: data width, bus mode and responder FSM encoding.
// No logic; imported by the responder top and its sub-module.
package spi_pkg;

    localparam int SPI_WIDTH    = 8;
    localparam int SPI_SYNC_MIN = 2;

    // Only mode 0 is supported: idle-low clock, sample on the leading edge.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    function automatic int sync_depth(input int req);
        return (req < SPI_SYNC_MIN) ? SPI_SYNC_MIN : req;
    endfunction

endpackage

// File: rtl/spi_slave_responder_if.sv
// SPI pins plus the local TX/RX buffer handshake of the SPI responder.
// slave = responder view, master = local logic / external master view.
interface spi_slave_responder_if #(
    parameter int WIDTH = 8
);
    logic             SCK;
    logic             CS_N;
    logic             MOSI;
    logic             MISO;
    logic             MISO_OE;
    logic [WIDTH-1:0] DATA_IN;
    logic             WRITE;
    logic             TX_FULL_STATE;
    logic             TX_EMPTY_STATE;
    logic [WIDTH-1:0] DATA_OUT;
    logic             READ;
    logic             RX_FULL_STATE;
    logic             RX_EMPTY_STATE;
    logic             OVERRUN;
    logic             BUSY;

    modport slave (
        input  SCK, CS_N, MOSI, DATA_IN, WRITE, READ,
        output MISO, MISO_OE, TX_FULL_STATE, TX_EMPTY_STATE, DATA_OUT,
               RX_FULL_STATE, RX_EMPTY_STATE, OVERRUN, BUSY
    );

    modport master (
        output SCK, CS_N, MOSI, DATA_IN, WRITE, READ,
        input  MISO, MISO_OE, TX_FULL_STATE, TX_EMPTY_STATE, DATA_OUT,
               RX_FULL_STATE, RX_EMPTY_STATE, OVERRUN, BUSY
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizer for one asynchronous pin plus rise/fall single-cycle event pulses.
// Latency: STAGES flops to the synchronized level; pulses are acted on STAGES+1 CLK after the pin moves.
// No backpressure: events are one-cycle pulses.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic CLR,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder: oversamples SCK/CS_N/MOSI, shifts one byte in while shifting a response out.
// Latency: pin events act SYNC_STAGES+1 CLK late; RX byte lands in DATA_OUT on the completing SCK rise.
// Backpressure: single-entry TX/RX buffers; RX full drops new bytes and sets sticky OVERRUN. Macro SPI_SLAVE_LSB_FIRST_EN selects LSB-first.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int               WIDTH       = SPI_WIDTH,
    parameter logic [WIDTH-1:0] TX_DEFAULT  = '0,
    parameter int               SYNC_STAGES = 2
) (
    input logic                  CLK,
    input logic                  CLR,
    spi_slave_responder_if.slave bus
);

    localparam int               SYNC_N   = sync_depth(SYNC_STAGES);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic sck_smp, sck_shf;

    spi_sync_edge #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_sck_sync (
        .CLK      (CLK),
        .CLR      (CLR),
        .async_in (bus.SCK),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    // CS_N resets to the deselected level so reset never fabricates a select.
    spi_sync_edge #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_cs_sync (
        .CLK      (CLK),
        .CLR      (CLR),
        .async_in (bus.CS_N),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    assign sck_smp = (SPI_CPOL == SPI_CPHA) ? sck_rise : sck_fall;
    assign sck_shf = (SPI_CPOL == SPI_CPHA) ? sck_fall : sck_rise;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              reload_q, reload_d;
    logic [SYNC_N-1:0] mosi_sync_q, mosi_sync_d;
    logic [WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]  tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic              rx_full_q, rx_full_d;
    logic              ovr_q, ovr_d;

    logic             mosi_s;
    logic [WIDTH-1:0] rx_nxt;
    logic [WIDTH-1:0] tx_nxt;
    logic             miso_bit;
    logic             tx_load;
    logic             byte_done;

    assign mosi_s = mosi_sync_q[SYNC_N-1];

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_nxt   = {mosi_s, rx_shift_q[WIDTH-1:1]};
    assign tx_nxt   = {1'b0, tx_shift_q[WIDTH-1:1]};
    assign miso_bit = tx_shift_q[0];
`else
    assign rx_nxt   = {rx_shift_q[WIDTH-2:0], mosi_s};
    assign tx_nxt   = {tx_shift_q[WIDTH-2:0], 1'b0};
    assign miso_bit = tx_shift_q[WIDTH-1];
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reload_d    = reload_q;
        mosi_sync_d = {mosi_sync_q[SYNC_N-2:0], bus.MOSI};
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        data_out_d  = data_out_q;
        rx_full_d   = rx_full_q;
        ovr_d       = ovr_q;
        tx_load     = 1'b0;
        byte_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d  = ST_ACTIVE;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                    tx_load  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                end else begin
                    if (sck_smp) begin
                        rx_shift_d = rx_nxt;
                        if (cnt_q == LAST_BIT) begin
                            cnt_d     = '0;
                            reload_d  = 1'b1;
                            byte_done = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    // Next byte is loaded on the shift edge after completion so bytes stream under one select.
                    if (sck_shf) begin
                        if (reload_q) begin
                            tx_load  = 1'b1;
                            reload_d = 1'b0;
                        end else begin
                            tx_shift_d = tx_nxt;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tx_load) begin
            tx_shift_d = tx_full_q ? tx_buf_q : TX_DEFAULT;
            tx_full_d  = 1'b0;
        end
        if (bus.WRITE && (tx_load || !tx_full_q)) begin
            tx_buf_d  = bus.DATA_IN;
            tx_full_d = 1'b1;
        end

        if (bus.READ) begin
            rx_full_d = 1'b0;
        end
        if (byte_done) begin
            if (!rx_full_q || bus.READ) begin
                data_out_d = rx_nxt;
                rx_full_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            reload_q    <= 1'b0;
            mosi_sync_q <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            data_out_q  <= '0;
            rx_full_q   <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reload_q    <= reload_d;
            mosi_sync_q <= mosi_sync_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            data_out_q  <= data_out_d;
            rx_full_q   <= rx_full_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.MISO           = (state_q == ST_ACTIVE) & miso_bit;
    assign bus.MISO_OE        = (state_q == ST_ACTIVE);
    assign bus.BUSY           = (state_q == ST_ACTIVE);
    assign bus.TX_FULL_STATE  = tx_full_q;
    assign bus.TX_EMPTY_STATE = ~tx_full_q;
    assign bus.DATA_OUT       = data_out_q;
    assign bus.RX_FULL_STATE  = rx_full_q;
    assign bus.RX_EMPTY_STATE = ~rx_full_q;
    assign bus.OVERRUN        = ovr_q;

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- Responder (slave) end of the team's SPI link; pairs with the existing SENDER/RECEIVER master-side shift registers.
- Oversamples externally driven SCK/CS_N/MOSI on the system clock, shifts in one byte per transfer and shifts a response byte out on MISO simultaneously.
- Presents a single-entry RX buffer and a single-entry TX buffer to local logic with the same WRITE/READ and FULL/EMPTY handshake used elsewhere in the codebase.
- SPI mode 0 only (CPOL=0, CPHA=0).

Parameters:
- WIDTH, 8, bits per transfer.
- TX_DEFAULT, 8'h00, byte shifted out when TX buffer is empty at load time.
- SYNC_STAGES, 2, synchronizer depth on SCK, CS_N and MOSI (minimum 2).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- SCK  in  1  SPI clock from master (asynchronous to CLK).
- CS_N  in  1  chip select, active-low (asynchronous).
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master.
- MISO_OE  out  1  1 while selected; board tristate enable.
- DATA_IN  in  WIDTH  response byte to load.
- WRITE  in  1  1-cycle strobe; loads DATA_IN into TX buffer.
- TX_FULL_STATE  out  1  TX buffer holds unsent byte.
- TX_EMPTY_STATE  out  1  inverse of TX_FULL_STATE.
- DATA_OUT  out  WIDTH  last received byte; valid while RX_FULL_STATE=1.
- READ  in  1  1-cycle strobe; consumes RX buffer.
- RX_FULL_STATE  out  1  unread byte present.
- RX_EMPTY_STATE  out  1  inverse of RX_FULL_STATE.
- OVERRUN  out  1  sticky; byte arrived while RX buffer full.
- BUSY  out  1  in ACTIVE state.

Behaviour:
- Reset (CLR=1 at CLK edge): MISO=0, MISO_OE=0, DATA_OUT=0, TX_FULL_STATE=0, TX_EMPTY_STATE=1, RX_FULL_STATE=0, RX_EMPTY_STATE=1, OVERRUN=0, BUSY=0, bit counter=0, FSM=IDLE. Reset mid-transfer aborts the transfer silently; the partial byte is discarded.
- Sync: SYNC_STAGES flops plus one edge-detect flop per input. Pin-to-event latency is SYNC_STAGES+1 CLK. Requires f_CLK >= 8*f_SCK.
- FSM IDLE: MISO=0, MISO_OE=0. On detected CS_N fall: go to ACTIVE, BUSY=1, MISO_OE=1, counter=0, load TX shift register.
  - If TX_FULL_STATE=1, load from the TX buffer and clear TX_FULL_STATE.
  - Otherwise load TX_DEFAULT.
  - MISO drives shift[WIDTH-1] immediately.
- FSM ACTIVE:
  - SCK rising event: sample the synchronized MOSI into the RX shift register; counter+1.
  - SCK falling event: shift TX left; MISO = next bit.
  - Byte completion, on the rising event where counter reaches WIDTH:
    - If RX_FULL_STATE=0, or READ is asserted in the same cycle: DATA_OUT <= RX shift, RX_FULL_STATE=1.
    - Otherwise the new byte is dropped, DATA_OUT is unchanged, and OVERRUN=1.
    - Counter returns to 0, and the TX shift register reloads (buffer or TX_DEFAULT) on the following falling event so back-to-back bytes stream without CS_N toggling.
- Detected CS_N rise in any state returns to IDLE. A partial byte (counter != 0) is discarded with no RX_FULL_STATE change; the TX buffer is untouched if not yet loaded.
- WRITE while TX_FULL_STATE=1 and no load in the same cycle: ignored, buffer keeps the old byte.
- WRITE in the same cycle as a load: the load consumes the old buffer content (or TX_DEFAULT if empty), then DATA_IN is stored and TX_FULL_STATE=1.
- READ while RX_FULL_STATE=0: no effect. READ clears RX_FULL_STATE next edge; DATA_OUT holds its value.
- OVERRUN clears only on CLR.
- SCK edges seen while in IDLE are ignored.

Optional Feature:
- Macro: SPI_SLAVE_LSB_FIRST_EN.
- Defined: both directions are LSB-first. MOSI shifts in at the MSB and the register shifts right; MISO = shift[0] and the register shifts right on falling events.
- Undefined: MSB-first as described above.

Decomposition:
- Shared package spi_pkg: WIDTH default, mode constants, FSM state encoding (ST_IDLE, ST_ACTIVE).
- One natural sub-module: spi_sync_edge (synchronizer plus rise/fall pulse generator), instantiated for SCK and CS_N. MOSI uses the sync chain only.

Test Plan:
- Reset then idle: CLR high 1 cycle -> every output at its reset value; MISO_OE=0 while CS_N=1.
- Basic exchange: WRITE DATA_IN=0x5F, master sends 0x43 -> RX_FULL_STATE=1, DATA_OUT=0x43, master receives 0x5F, TX_EMPTY_STATE=1 after CS_N fall.
- Empty TX: no WRITE, master sends 0xA5 -> master receives TX_DEFAULT 0x00, DATA_OUT=0xA5.
- Overrun: two bytes 0x11 then 0x22 with no READ -> DATA_OUT=0x11, OVERRUN=1. A third byte 0x33 with a READ pulse coincident with its completion -> DATA_OUT=0x33, RX_FULL_STATE=1.
- Abort: CS_N rises after 5 SCK rising edges -> RX_FULL_STATE stays 0, counter 0, FSM=IDLE. The next full byte 0x3C is received correctly.
- Reset mid-byte: CLR pulse after 3 bits -> all outputs at reset values. A subsequent transfer of 0xC3 is received correctly; repeat with SPI_SLAVE_LSB_FIRST_EN defined to confirm bit order reversal.
